// File: rtl/branch_hazard_ctrl.sv
// Purpose : hazard/sequencing controller for the 5-stage core. It keeps shadow copies of
//           {dest, we, load} for ID/EX, EX/MEM and MEM/WB, plus the ID/EX source regs.
// Latency : stall, bubble, flush and forward selects are combinational from decode and the
//           shadows. stall_state and the counters are registered.
// Backpressure: stall holds PC and IF/ID and pushes a bubble into ID/EX. Flush is suppressed
//           while stalled, so the branch is re-evaluated on the next cycle.
// Ports   : decode fields (*_ID) in; branch/EX forward selects, stall, bubble_IDEX and
//           flush_IFID out; stall_state and the saturating stall/flush counters for debug.
module branch_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs_ID,
   input  logic [4:0]       rt_ID,
   input  logic [4:0]       DestReg_ID,
   input  logic             RegWriteEn_ID,
   input  logic             MemReadEn_ID,
   input  logic             Branch_ID,
   input  logic             jump_ID,
   input  logic             jal_ID,
   input  logic             jr_ID,
   input  logic             PCSrc_ID,
   output logic [1:0]       ForwardA_branch,
   output logic [1:0]       ForwardB_branch,
   output logic [1:0]       ForwardA_EX,
   output logic [1:0]       ForwardB_EX,
   output logic             stall,
   output logic             bubble_IDEX,
   output logic             flush_IFID,
   output logic [1:0]       stall_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_ALU1   = 2'd1,
      ST_LD1    = 2'd2,
      ST_LD2    = 2'd3
   } state_t;

   typedef struct packed {
      logic [4:0] dest;
      logic       we;
      logic       ld;
   } stg_t;

   stg_t             r_idex, r_exmem, r_memwb;
   logic [4:0]       r_idex_rs, r_idex_rt;
   state_t           r_state;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   // A stage produces reg r if it writes it; $0 never counts as a dependency.
   function automatic logic hit(input stg_t s, input logic [4:0] r);
      return s.we && (s.dest == r) && (r != 5'd0);
   endfunction

   logic w_is_br, w_use_rt;
   logic w_rs_idex, w_rt_idex, w_rs_exm, w_rt_exm;
   logic w_cond_a, w_cond_b, w_cond_c, w_stall, w_flush;

   // Branches read rs and rt, jr reads rs only. Anything else is assumed to read rt unless
   // rt is plainly its own destination. This is conservative on purpose.
   assign w_is_br  = Branch_ID | jr_ID;
   assign w_use_rt = Branch_ID | (~jr_ID & (~RegWriteEn_ID | (DestReg_ID != rt_ID)));

   assign w_rs_idex = hit(r_idex, rs_ID);
   assign w_rt_idex = w_use_rt & hit(r_idex, rt_ID);
   assign w_rs_exm  = hit(r_exmem, rs_ID);
   assign w_rt_exm  = w_use_rt & hit(r_exmem, rt_ID);

   // Compare happens in decode, so a producer still in EX (any kind) or a load still in MEM
   // cannot be forwarded in time.
   assign w_cond_a = w_is_br & (w_rs_idex | w_rt_idex);
   assign w_cond_b = w_is_br & r_exmem.ld & (w_rs_exm | w_rt_exm);
   assign w_cond_c = r_idex.ld & (w_rs_idex | w_rt_idex);
   assign w_stall  = w_cond_a | w_cond_b | w_cond_c;
   assign w_flush  = ~w_stall & (jump_ID | jal_ID | jr_ID | (Branch_ID & PCSrc_ID));

   // A load result in EX/MEM is not ready yet, so only ALU results forward from MEM.
   function automatic logic [1:0] fwd_sel(input logic [4:0] r);
      if (hit(r_exmem, r) && !r_exmem.ld) return 2'd1;
      else if (hit(r_memwb, r))           return 2'd2;
      else                                return 2'd0;
   endfunction

   assign ForwardA_branch = w_stall ? 2'd0 : fwd_sel(rs_ID);
   assign ForwardB_branch = w_stall ? 2'd0 : fwd_sel(rt_ID);
   assign ForwardA_EX     = fwd_sel(r_idex_rs);
   assign ForwardB_EX     = fwd_sel(r_idex_rt);
   assign stall           = w_stall;
   assign bubble_IDEX     = w_stall;
   assign flush_IFID      = w_flush;
   assign stall_state     = r_state;
   assign stall_count     = r_stall_cnt;
   assign flush_count     = r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idex      <= '0;
         r_exmem     <= '0;
         r_memwb     <= '0;
         r_idex_rs   <= '0;
         r_idex_rt   <= '0;
         r_state     <= ST_NORMAL;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_exmem <= r_idex;
         r_memwb <= r_exmem;
         if (w_stall) begin
            r_idex    <= '0;
            r_idex_rs <= '0;
            r_idex_rt <= '0;
         end else begin
            r_idex.dest <= jal_ID ? 5'd31 : DestReg_ID;
            r_idex.we   <= RegWriteEn_ID;
            r_idex.ld   <= MemReadEn_ID;
            r_idex_rs   <= rs_ID;
            r_idex_rt   <= rt_ID;
         end

         // The state only records why the core stalled. The stall itself always
         // comes from the shadows.
         case (r_state)
            ST_NORMAL: begin
               if (w_stall) begin
                  if ((w_cond_a | w_cond_c) & r_idex.ld) r_state <= ST_LD1;
                  else if (w_cond_a)                     r_state <= ST_ALU1;
                  else                                   r_state <= ST_LD2;
               end
            end
            ST_LD1:  r_state <= w_cond_b ? ST_LD2 : ST_NORMAL;
            default: r_state <= ST_NORMAL;
         endcase

         if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

   localparam int CNT_W = 10;

   typedef struct packed {
      logic [4:0] rs, rt, dest;
      logic       we, ld, br, pc, j, jal, jr;
   } stim_t;

   typedef struct packed {
      logic             stall, bubble, flush;
      logic [1:0]       fab, fbb, fae, fbe, st;
      logic [CNT_W-1:0] sc, fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] rs_ID = '0, rt_ID = '0, DestReg_ID = '0;
   logic RegWriteEn_ID = 0, MemReadEn_ID = 0, Branch_ID = 0, jump_ID = 0;
   logic jal_ID = 0, jr_ID = 0, PCSrc_ID = 0;
   logic [1:0] ForwardA_branch, ForwardB_branch, ForwardA_EX, ForwardB_EX, stall_state;
   logic stall, bubble_IDEX, flush_IFID;
   logic [CNT_W-1:0] stall_count, flush_count;

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];
   logic [CNT_W-1:0] m_sc, m_fc;
   exp_t obs;

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .rs_ID(rs_ID), .rt_ID(rt_ID), .DestReg_ID(DestReg_ID),
      .RegWriteEn_ID(RegWriteEn_ID), .MemReadEn_ID(MemReadEn_ID),
      .Branch_ID(Branch_ID), .jump_ID(jump_ID), .jal_ID(jal_ID), .jr_ID(jr_ID),
      .PCSrc_ID(PCSrc_ID),
      .ForwardA_branch(ForwardA_branch), .ForwardB_branch(ForwardB_branch),
      .ForwardA_EX(ForwardA_EX), .ForwardB_EX(ForwardB_EX),
      .stall(stall), .bubble_IDEX(bubble_IDEX), .flush_IFID(flush_IFID),
      .stall_state(stall_state), .stall_count(stall_count), .flush_count(flush_count)
   );

   always_comb obs = {stall, bubble_IDEX, flush_IFID, ForwardA_branch, ForwardB_branch,
                      ForwardA_EX, ForwardB_EX, stall_state, stall_count, flush_count};

   // ---------------- instruction and expectation builders ----------------
   function automatic stim_t NOP();
      stim_t s = '0;
      return s;
   endfunction
   function automatic stim_t ALU(int d, int rs, int rt);
      stim_t s = '0;
      s.dest = 5'(d); s.rs = 5'(rs); s.rt = 5'(rt); s.we = 1'b1;
      return s;
   endfunction
   function automatic stim_t LW(int d, int rs);
      stim_t s = '0;
      s.dest = 5'(d); s.rs = 5'(rs); s.we = 1'b1; s.ld = 1'b1;
      return s;
   endfunction
   function automatic stim_t BEQ(int rs, int rt, bit taken);
      stim_t s = '0;
      s.rs = 5'(rs); s.rt = 5'(rt); s.br = 1'b1; s.pc = taken;
      return s;
   endfunction
   function automatic stim_t JAL();
      stim_t s = '0;
      s.jal = 1'b1; s.we = 1'b1;
      return s;
   endfunction
   function automatic stim_t JR(int rs);
      stim_t s = '0;
      s.rs = 5'(rs); s.jr = 1'b1;
      return s;
   endfunction
   function automatic stim_t JMP();
      stim_t s = '0;
      s.j = 1'b1;
      return s;
   endfunction
   function automatic exp_t E(bit st_, bit fl, int fab, int fbb, int fae, int fbe, int st);
      exp_t e = '0;
      e.stall = st_; e.bubble = st_; e.flush = fl;
      e.fab = 2'(fab); e.fbb = 2'(fbb); e.fae = 2'(fae); e.fbe = 2'(fbe); e.st = 2'(st);
      return e;
   endfunction

   // Drives one decode cycle and queues what the DUT must show during it. The model
   // counters hold the value the DUT should show during this cycle.
   task automatic issue(input stim_t s, input exp_t e);
      rs_ID = s.rs; rt_ID = s.rt; DestReg_ID = s.dest;
      RegWriteEn_ID = s.we; MemReadEn_ID = s.ld; Branch_ID = s.br; PCSrc_ID = s.pc;
      jump_ID = s.j; jal_ID = s.jal; jr_ID = s.jr;
      e.sc = m_sc; e.fc = m_fc;
      exp_q.push_back(e);
      if (e.stall && m_sc != {CNT_W{1'b1}}) m_sc = m_sc + 1'b1;
      if (e.flush && m_fc != {CNT_W{1'b1}}) m_fc = m_fc + 1'b1;
   endtask

   task automatic do_reset();
      issue(NOP(), E(0,0,0,0,0,0,0));
      void'(exp_q.pop_front());
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_sc = '0; m_fc = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      exp_t got;
      do_reset();
      issue(NOP(), E(0,0,0,0,0,0,0));
      @(negedge clk);
      got = exp_q.pop_front(); checks++;
      if (obs !== got) begin errors++; $display("FAIL reset: got %h want %h", obs, got); end
      @(posedge clk); #1;
   endtask

   task automatic test_alu_branch();
      stim_t s[4]; exp_t e[4]; exp_t got;
      s = '{ALU(3,8,9), BEQ(3,4,1), BEQ(3,4,1), NOP()};
      e = '{E(0,0,0,0,0,0,0), E(1,0,0,0,0,0,0), E(0,1,1,0,0,0,1), E(0,0,0,0,2,0,0)};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(s[i], e[i]);
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL alu_branch cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_branch();
      stim_t s[5]; exp_t e[5]; exp_t got;
      s = '{LW(5,8), BEQ(5,0,0), BEQ(5,0,0), BEQ(5,0,0), NOP()};
      e = '{E(0,0,0,0,0,0,0), E(1,0,0,0,0,0,0), E(1,0,0,0,0,0,2), E(0,0,2,0,0,0,3),
            E(0,0,0,0,0,0,0)};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         issue(s[i], e[i]);
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL load_branch cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t s[4]; exp_t e[4]; exp_t got;
      s = '{LW(6,8), ALU(7,6,6), ALU(7,6,6), NOP()};
      e = '{E(0,0,0,0,0,0,0), E(1,0,0,0,0,0,0), E(0,0,0,0,0,0,2), E(0,0,0,0,2,2,0)};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(s[i], e[i]);
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL load_use cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[5]; exp_t e[5]; exp_t got;
      s = '{ALU(2,8,9), ALU(2,8,9), BEQ(2,9,1), BEQ(2,9,1), NOP()};
      e = '{E(0,0,0,0,0,0,0), E(0,0,0,0,0,0,0), E(1,0,0,0,0,0,0), E(0,1,1,0,0,0,1),
            E(0,0,0,0,2,0,0)};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         issue(s[i], e[i]);
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_zero_jal_jr();
      stim_t s[8]; exp_t e[8]; exp_t got;
      s = '{ALU(0,8,9), LW(0,8), BEQ(0,0,1), NOP(), JAL(), JR(31), JR(31), NOP()};
      e = '{E(0,0,0,0,0,0,0), E(0,0,0,0,0,0,0), E(0,1,0,0,0,0,0), E(0,0,0,0,0,0,0),
            E(0,1,0,0,0,0,0), E(1,0,0,0,0,0,0), E(0,1,1,0,0,0,1), E(0,0,0,0,2,0,0)};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         issue(s[i], e[i]);
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL zero_jal_jr cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midstall();
      stim_t s[2]; exp_t e[2]; exp_t got;
      s = '{LW(5,8), BEQ(5,0,0)};
      e = '{E(0,0,0,0,0,0,0), E(1,0,0,0,0,0,0)};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         issue(s[i], e[i]);
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL midstall_pre cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
      // Reset lands while the branch is still waiting on the load in EX/MEM.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_sc = '0; m_fc = '0;
      issue(BEQ(5,0,0), E(0,0,0,0,0,0,0));
      @(negedge clk);
      got = exp_q.pop_front(); checks++;
      if (obs !== got) begin errors++; $display("FAIL midstall_reset: got %h want %h", obs, got); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall_saturation();
      exp_t got;
      do_reset();
      for (int k = 0; k < 520; k++) begin
         for (int p = 0; p < 3; p++) begin
            if (p == 0)      issue(LW(5,8),       E(0,0,0,0,0,0,(k == 0) ? 0 : 3));
            else if (p == 1) issue(BEQ(5,0,0),    E(1,0,0,0,0,0,0));
            else             issue(BEQ(5,0,0),    E(1,0,0,0,0,0,2));
            @(negedge clk);
            got = exp_q.pop_front(); checks++;
            if (obs !== got) begin errors++; $display("FAIL stall_sat k %0d p %0d: got %h want %h", k, p, obs, got); end
            @(posedge clk); #1;
         end
      end
      checks++;
      if (stall_count !== {CNT_W{1'b1}}) begin
         errors++; $display("FAIL stall_count_hold: got %h want %h", stall_count, {CNT_W{1'b1}});
      end
   endtask

   task automatic test_flush_saturation();
      exp_t got;
      do_reset();
      for (int i = 0; i < (1 << CNT_W) + 6; i++) begin
         issue(JMP(), E(0,1,0,0,0,0,0));
         @(negedge clk);
         got = exp_q.pop_front(); checks++;
         if (obs !== got) begin errors++; $display("FAIL flush_sat cyc %0d: got %h want %h", i, obs, got); end
         @(posedge clk); #1;
      end
      checks++;
      if (flush_count !== {CNT_W{1'b1}}) begin
         errors++; $display("FAIL flush_count_hold: got %h want %h", flush_count, {CNT_W{1'b1}});
      end
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      m_sc = '0; m_fc = '0;
      test_reset();
      test_alu_branch();
      test_load_branch();
      test_load_use();
      test_back_to_back();
      test_zero_jal_jr();
      test_reset_midstall();
      test_stall_saturation();
      test_flush_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
